axi_ni_request_scheduler: RTL and testbench

Per-ID transaction scheduler for the AXI initiator NI request path. Chooses which AXI ID and direction (write or read) the request FSM serialises into the next NoC packet, using round-robin arbitration over the per-ID AW/W/AR FIFOs. It tracks outstanding transactions per ID against configured limits and holds each grant until the packet has left the NI. It sits between the per-ID synch FIFOs and the request FSM, in the core clock domain.

---
 rtl/axi_ni_request_scheduler_pkg.sv | 19 +
 rtl/axi_ni_request_scheduler_if.sv | 36 +++
 rtl/axi_ni_request_scheduler_rr_arbiter.sv | 28 ++
 rtl/axi_ni_request_scheduler.sv | 136 +++++++++++++
 tb/tb_axi_ni_request_scheduler.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/axi_ni_request_scheduler_pkg.sv
// Shared types and helpers for the AXI NI request scheduler.
// Scheduler FSM encoding and slot-index width derivation.
package axi_ni_request_scheduler_pkg;

    typedef enum logic {
        SchedIdle = 1'b0,
        SchedBusy = 1'b1
    } sched_state_e;

    // A slot is {id, dir}: one extra bit on top of the ID width.
    function automatic int unsigned slot_idx_width(input int unsigned id_wd);
        return id_wd + 1;
    endfunction

    localparam int unsigned DefaultIds   = 16;
    localparam int unsigned DefaultIdWd  = 4;
    localparam int unsigned DefaultSlotWd = slot_idx_width(DefaultIdWd);

endpackage

// File: rtl/axi_ni_request_scheduler_if.sv
// Bundle of per-ID FIFO status, retirement pulses and grant outputs between
// the scheduler (master) and the NI request path (slave).
interface axi_ni_request_scheduler_if #(
    parameter int unsigned N     = 16,
    parameter int unsigned ID_WD = 4
) ();

    logic [N-1:0]     aw_rempty;
    logic [N-1:0]     wd_rempty;
    logic [N-1:0]     ar_rempty;
    logic             tx_gone;
    logic [N-1:0]     decr_outs_wr_cntr;
    logic [N-1:0]     decr_outs_rd_cntr;
    logic             grant_valid;
    logic [ID_WD-1:0] grant_tid;
    logic             grant_write;
    logic [N-1:0]     response_awaited;
    logic [N-1:0]     outs_wr_max;
    logic [N-1:0]     outs_rd_max;
    logic             cnt_unfl_err;

    modport master (
        input  aw_rempty, wd_rempty, ar_rempty, tx_gone,
        input  decr_outs_wr_cntr, decr_outs_rd_cntr,
        output grant_valid, grant_tid, grant_write,
        output response_awaited, outs_wr_max, outs_rd_max, cnt_unfl_err
    );

    modport slave (
        output aw_rempty, wd_rempty, ar_rempty, tx_gone,
        output decr_outs_wr_cntr, decr_outs_rd_cntr,
        input  grant_valid, grant_tid, grant_write,
        input  response_awaited, outs_wr_max, outs_rd_max, cnt_unfl_err
    );

endinterface

// File: rtl/axi_ni_request_scheduler_rr_arbiter.sv
// Combinational round-robin find-first-set: searches req starting one slot
// after ptr, wrapping around, and returns the first set index.
module ni_rr_arbiter #(
    parameter int unsigned WIDTH = 32,
    localparam int unsigned IdxWd = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] req,
    input  logic [IdxWd-1:0] ptr,
    output logic             gnt_valid,
    output logic [IdxWd-1:0] gnt_idx
);

    int unsigned slot;

    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        slot      = 0;
        for (int unsigned k = 1; k <= WIDTH; k++) begin
            slot = (32'(ptr) + k) % WIDTH;
            if (!gnt_valid && req[IdxWd'(slot)]) begin
                gnt_valid = 1'b1;
                gnt_idx   = IdxWd'(slot);
            end
        end
    end

endmodule

// File: rtl/axi_ni_request_scheduler.sv
// Per-ID request scheduler: round-robin over write/read slots, outstanding
// transaction tracking per ID, grant held until the packet has left the NI.
module axi_ni_request_scheduler
    import axi_ni_request_scheduler_pkg::*;
#(
    parameter int unsigned MAX_SUPPORTED_IDS                 = DefaultIds,
    parameter int unsigned ID_WD                             = DefaultIdWd,
    parameter logic [MAX_SUPPORTED_IDS-1:0] ID_MAP           = {MAX_SUPPORTED_IDS{1'b1}},
    parameter int unsigned LOG_MAX_OUTSTANDING_WRITES_PER_ID = 4,
    parameter int unsigned LOG_MAX_OUTSTANDING_READS_PER_ID  = 0
) (
    input logic                          clk,
    input logic                          rst,
    axi_ni_request_scheduler_if.master   bus
);

    localparam int unsigned N       = MAX_SUPPORTED_IDS;
    localparam int unsigned SLOTS   = 2 * N;
    localparam int unsigned SLOT_WD = slot_idx_width(ID_WD);
    localparam int unsigned WR_W    = LOG_MAX_OUTSTANDING_WRITES_PER_ID + 1;
    localparam int unsigned RD_W    = LOG_MAX_OUTSTANDING_READS_PER_ID + 1;
    localparam logic [WR_W-1:0] WR_LIMIT = WR_W'(1) << LOG_MAX_OUTSTANDING_WRITES_PER_ID;
    localparam logic [RD_W-1:0] RD_LIMIT = RD_W'(1) << LOG_MAX_OUTSTANDING_READS_PER_ID;

    sched_state_e       state_q, state_d;
    logic [SLOT_WD-1:0] ptr_q, ptr_d;
    logic [ID_WD-1:0]   tid_q, tid_d;
    logic               write_q, write_d;
    logic               err_q;

    logic [SLOTS-1:0]   req;
    logic               win_valid;
    logic [SLOT_WD-1:0] win_idx;
    logic               take;
    logic [N-1:0]       unfl, wr_max, rd_max, awaited;

    ni_rr_arbiter #(
        .WIDTH (SLOTS)
    ) u_arb (
        .req       (req),
        .ptr       (ptr_q),
        .gnt_valid (win_valid),
        .gnt_idx   (win_idx)
    );

    assign take = (state_q == SchedIdle) && win_valid;

    for (genvar i = 0; i < N; i++) begin : g_id
        if (ID_MAP[i]) begin : g_mapped
            logic [WR_W-1:0] wr_cnt_q;
            logic [RD_W-1:0] rd_cnt_q;
            logic            wr_inc, wr_dec, rd_inc, rd_dec;

            assign wr_inc = take && (win_idx == SLOT_WD'(2 * i));
            assign rd_inc = take && (win_idx == SLOT_WD'(2 * i + 1));
            assign wr_dec = bus.decr_outs_wr_cntr[i];
            assign rd_dec = bus.decr_outs_rd_cntr[i];

            // Simultaneous inc/dec cancel out; a lone dec at zero saturates.
            always_ff @(posedge clk) begin
                if (rst) begin
                    wr_cnt_q <= '0;
                    rd_cnt_q <= '0;
                end else begin
                    if (wr_inc && !wr_dec) wr_cnt_q <= wr_cnt_q + WR_W'(1);
                    else if (wr_dec && !wr_inc && wr_cnt_q != '0) wr_cnt_q <= wr_cnt_q - WR_W'(1);
                    if (rd_inc && !rd_dec) rd_cnt_q <= rd_cnt_q + RD_W'(1);
                    else if (rd_dec && !rd_inc && rd_cnt_q != '0) rd_cnt_q <= rd_cnt_q - RD_W'(1);
                end
            end

            assign unfl[i]    = (wr_dec && !wr_inc && wr_cnt_q == '0) ||
                                (rd_dec && !rd_inc && rd_cnt_q == '0);
            assign wr_max[i]  = (wr_cnt_q == WR_LIMIT);
            assign rd_max[i]  = (rd_cnt_q == RD_LIMIT);
            assign awaited[i] = (wr_cnt_q != '0) || (rd_cnt_q != '0);
            assign req[2*i]   = !bus.aw_rempty[i] && !bus.wd_rempty[i] && !wr_max[i];
            assign req[2*i+1] = !bus.ar_rempty[i] && !rd_max[i];
        end else begin : g_unmapped
            assign unfl[i]    = 1'b0;
            assign wr_max[i]  = 1'b0;
            assign rd_max[i]  = 1'b0;
            assign awaited[i] = 1'b0;
            assign req[2*i]   = 1'b0;
            assign req[2*i+1] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SchedIdle;
            ptr_q   <= SLOT_WD'(SLOTS - 1);
            tid_q   <= '0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            tid_q   <= tid_d;
            write_q <= write_d;
            err_q   <= err_q | (|unfl);
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        tid_d   = tid_q;
        write_d = write_q;
        unique case (state_q)
            SchedIdle: begin
                if (win_valid) begin
                    state_d = SchedBusy;
                    ptr_d   = win_idx;
                    tid_d   = win_idx[SLOT_WD-1:1];
                    write_d = ~win_idx[0];
                end
            end
            SchedBusy: begin
                if (bus.tx_gone) state_d = SchedIdle;
            end
            default: state_d = SchedIdle;
        endcase
    end

    always_comb begin
        bus.grant_valid      = (state_q == SchedBusy);
        bus.grant_tid        = tid_q;
        bus.grant_write      = write_q;
        bus.response_awaited = awaited;
        bus.outs_wr_max      = wr_max;
        bus.outs_rd_max      = rd_max;
        bus.cnt_unfl_err     = err_q;
    end

endmodule

// File: tb/tb_axi_ni_request_scheduler.sv
// Self-checking bench: directed vector table for the corner cases, then random
// traffic compared against a slot-list reference model of the scheduler.
module tb_axi_ni_request_scheduler;

    localparam int unsigned N     = 16;
    localparam int unsigned IDW   = 4;
    localparam logic [15:0] MAP   = 16'hFF7F;
    localparam int unsigned LOGW  = 2;
    localparam int unsigned LOGR  = 0;
    localparam int          WRLIM = 1 << LOGW;
    localparam int          RDLIM = 1 << LOGR;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    axi_ni_request_scheduler_if #(.N(N), .ID_WD(IDW)) bus ();

    axi_ni_request_scheduler #(
        .MAX_SUPPORTED_IDS                 (N),
        .ID_WD                             (IDW),
        .ID_MAP                            (MAP),
        .LOG_MAX_OUTSTANDING_WRITES_PER_ID (LOGW),
        .LOG_MAX_OUTSTANDING_READS_PER_ID  (LOGR)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state
    logic [15:0] map_v = MAP;
    int  m_wr[N];
    int  m_rd[N];
    bit  m_busy, m_err, m_w, m_fresh;
    int  m_last, m_tid;

    task automatic drive(input bit r, input bit txg, input logic [15:0] aw_ne,
                         input logic [15:0] wd_ne, input logic [15:0] ar_ne,
                         input logic [15:0] dw, input logic [15:0] dr);
        rst                   = r;
        bus.tx_gone           = txg;
        bus.aw_rempty         = ~aw_ne;
        bus.wd_rempty         = ~wd_ne;
        bus.ar_rempty         = ~ar_ne;
        bus.decr_outs_wr_cntr = dw;
        bus.decr_outs_rd_cntr = dr;
    endtask

    task automatic model_step();
        int win, s, id;
        if (rst) begin
            m_busy = 0; m_err = 0; m_w = 0; m_tid = 0; m_fresh = 1;
            m_last = 2 * N - 1;
            for (int i = 0; i < N; i++) begin m_wr[i] = 0; m_rd[i] = 0; end
            return;
        end
        win = -1;
        if (!m_busy) begin
            for (int k = 1; k <= 2 * N; k++) begin
                s  = (m_last + k) % (2 * N);
                id = s / 2;
                if (win < 0 && map_v[id]) begin
                    if (s % 2 == 0) begin
                        if (!bus.aw_rempty[id] && !bus.wd_rempty[id] && m_wr[id] < WRLIM) win = s;
                    end else if (!bus.ar_rempty[id] && m_rd[id] < RDLIM) win = s;
                end
            end
        end else if (bus.tx_gone) m_busy = 0;
        if (win >= 0) begin
            m_busy = 1; m_last = win; m_tid = win / 2; m_w = (win % 2 == 0); m_fresh = 0;
        end
        for (int i = 0; i < N; i++) begin
            if (map_v[i]) begin
                if (win == 2 * i && !bus.decr_outs_wr_cntr[i]) m_wr[i]++;
                else if (win != 2 * i && bus.decr_outs_wr_cntr[i]) begin
                    if (m_wr[i] == 0) m_err = 1; else m_wr[i]--;
                end
                if (win == 2 * i + 1 && !bus.decr_outs_rd_cntr[i]) m_rd[i]++;
                else if (win != 2 * i + 1 && bus.decr_outs_rd_cntr[i]) begin
                    if (m_rd[i] == 0) m_err = 1; else m_rd[i]--;
                end
            end
        end
    endtask

    task automatic check_model();
        logic [15:0] e_aw, e_wm, e_rm;
        for (int i = 0; i < N; i++) begin
            e_aw[i] = (m_wr[i] != 0) || (m_rd[i] != 0);
            e_wm[i] = (m_wr[i] == WRLIM);
            e_rm[i] = (m_rd[i] == RDLIM);
        end
        check("model_valid", 32'(bus.grant_valid), 32'(m_busy));
        if (m_busy || m_fresh) begin
            check("model_tid", 32'(bus.grant_tid), 32'(m_tid));
            check("model_write", 32'(bus.grant_write), 32'(m_w));
        end
        check("model_awaited", 32'(bus.response_awaited), 32'(e_aw));
        check("model_wr_max", 32'(bus.outs_wr_max), 32'(e_wm));
        check("model_rd_max", 32'(bus.outs_rd_max), 32'(e_rm));
        check("model_err", 32'(bus.cnt_unfl_err), 32'(m_err));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_model();
    endtask

    typedef struct {
        bit          r, txg;
        logic [15:0] aw, wd, ar, dw, dr;
        bit          v;
        logic [3:0]  tid;
        bit          w;
        logic [15:0] awt, rdmax;
        bit          err;
    } vec_t;

    function automatic vec_t mk(bit r, bit txg, logic [15:0] aw, logic [15:0] wd,
                                logic [15:0] ar, logic [15:0] dw, logic [15:0] dr, bit v,
                                logic [3:0] tid, bit w, logic [15:0] awt, logic [15:0] rdmax,
                                bit err);
        vec_t t;
        t.r = r; t.txg = txg; t.aw = aw; t.wd = wd; t.ar = ar; t.dw = dw; t.dr = dr;
        t.v = v; t.tid = tid; t.w = w; t.awt = awt; t.rdmax = rdmax; t.err = err;
        return t;
    endfunction

    vec_t vecs[32];

    initial begin
        //             r txg aw     wd     ar     dw     dr     v tid w awt    rdmax  err
        vecs[0]  = mk(1, 0, 'h0,   'h0,   'h0,   'h0,   'h0,   0, 0, 0, 'h0,  'h0,  0);
        vecs[1]  = mk(0, 0, 'h1,   'h1,   'h0,   'h0,   'h0,   1, 0, 1, 'h1,  'h0,  0);
        vecs[2]  = mk(0, 1, 'h1,   'h1,   'h0,   'h0,   'h0,   0, 0, 0, 'h1,  'h0,  0);
        vecs[3]  = mk(0, 0, 'h0,   'h0,   'h0,   'h1,   'h0,   0, 0, 0, 'h0,  'h0,  0);
        vecs[4]  = mk(0, 0, 'h4,   'h4,   'h0,   'h0,   'h0,   1, 2, 1, 'h4,  'h0,  0);
        vecs[5]  = mk(0, 1, 'h4,   'h4,   'h20,  'h0,   'h0,   0, 0, 0, 'h4,  'h0,  0);
        vecs[6]  = mk(0, 0, 'h4,   'h4,   'h20,  'h0,   'h0,   1, 5, 0, 'h24, 'h20, 0);
        vecs[7]  = mk(0, 1, 'h4,   'h4,   'h20,  'h0,   'h0,   0, 0, 0, 'h24, 'h20, 0);
        vecs[8]  = mk(0, 0, 'h4,   'h4,   'h20,  'h0,   'h0,   1, 2, 1, 'h24, 'h20, 0);
        vecs[9]  = mk(0, 1, 'h0,   'h0,   'h0,   'h0,   'h0,   0, 0, 0, 'h24, 'h20, 0);
        vecs[10] = mk(0, 0, 'h0,   'h0,   'h8,   'h0,   'h0,   1, 3, 0, 'h2C, 'h28, 0);
        vecs[11] = mk(0, 1, 'h0,   'h0,   'h8,   'h0,   'h0,   0, 0, 0, 'h2C, 'h28, 0);
        vecs[12] = mk(0, 0, 'h0,   'h0,   'h8,   'h0,   'h0,   0, 0, 0, 'h2C, 'h28, 0);
        vecs[13] = mk(0, 0, 'h0,   'h0,   'h8,   'h0,   'h8,   0, 0, 0, 'h24, 'h20, 0);
        vecs[14] = mk(0, 0, 'h0,   'h0,   'h8,   'h0,   'h0,   1, 3, 0, 'h2C, 'h28, 0);
        vecs[15] = mk(0, 1, 'h0,   'h0,   'h0,   'h4,   'h28,  0, 0, 0, 'h4,  'h0,  0);
        vecs[16] = mk(0, 0, 'h0,   'h0,   'h0,   'h4,   'h0,   0, 0, 0, 'h0,  'h0,  0);
        vecs[17] = mk(0, 0, 'h2,   'h2,   'h0,   'h0,   'h0,   1, 1, 1, 'h2,  'h0,  0);
        vecs[18] = mk(0, 1, 'h2,   'h2,   'h0,   'h0,   'h0,   0, 0, 0, 'h2,  'h0,  0);
        vecs[19] = mk(0, 0, 'h2,   'h2,   'h0,   'h0,   'h0,   1, 1, 1, 'h2,  'h0,  0);
        vecs[20] = mk(0, 1, 'h2,   'h2,   'h0,   'h0,   'h0,   0, 0, 0, 'h2,  'h0,  0);
        vecs[21] = mk(0, 0, 'h2,   'h2,   'h0,   'h2,   'h0,   1, 1, 1, 'h2,  'h0,  0);
        vecs[22] = mk(0, 1, 'h0,   'h0,   'h0,   'h2,   'h0,   0, 0, 0, 'h2,  'h0,  0);
        vecs[23] = mk(0, 0, 'h0,   'h0,   'h0,   'h2,   'h0,   0, 0, 0, 'h0,  'h0,  0);
        vecs[24] = mk(0, 0, 'h80,  'h80,  'h80,  'h80,  'h80,  0, 0, 0, 'h0,  'h0,  0);
        vecs[25] = mk(0, 0, 'h80,  'h80,  'h80,  'h0,   'h0,   0, 0, 0, 'h0,  'h0,  0);
        vecs[26] = mk(0, 0, 'h0,   'h0,   'h0,   'h10,  'h0,   0, 0, 0, 'h0,  'h0,  1);
        vecs[27] = mk(0, 0, 'h0,   'h0,   'h0,   'h0,   'h0,   0, 0, 0, 'h0,  'h0,  1);
        vecs[28] = mk(0, 0, 'h1,   'h1,   'h0,   'h0,   'h0,   1, 0, 1, 'h1,  'h0,  1);
        vecs[29] = mk(1, 0, 'h1,   'h1,   'h0,   'h0,   'h0,   0, 0, 0, 'h0,  'h0,  0);
        vecs[30] = mk(0, 0, 'h3,   'h3,   'h0,   'h0,   'h0,   1, 0, 1, 'h1,  'h0,  0);
        vecs[31] = mk(0, 1, 'h0,   'h0,   'h0,   'h0,   'h0,   0, 0, 0, 'h1,  'h0,  0);

        drive(1, 0, 0, 0, 0, 0, 0);
        #1;
        for (int i = 0; i < 32; i++) begin
            drive(vecs[i].r, vecs[i].txg, vecs[i].aw, vecs[i].wd, vecs[i].ar,
                  vecs[i].dw, vecs[i].dr);
            cycle();
            check($sformatf("vec%0d_valid", i), 32'(bus.grant_valid), 32'(vecs[i].v));
            if (vecs[i].v || vecs[i].r) begin
                check($sformatf("vec%0d_tid", i), 32'(bus.grant_tid), 32'(vecs[i].tid));
                check($sformatf("vec%0d_write", i), 32'(bus.grant_write), 32'(vecs[i].w));
            end
            check($sformatf("vec%0d_awaited", i), 32'(bus.response_awaited), 32'(vecs[i].awt));
            check($sformatf("vec%0d_rd_max", i), 32'(bus.outs_rd_max), 32'(vecs[i].rdmax));
            check($sformatf("vec%0d_err", i), 32'(bus.cnt_unfl_err), 32'(vecs[i].err));
        end

        for (int c = 0; c < 4000; c++) begin
            drive($urandom_range(0, 299) == 0,
                  $urandom_range(0, 2) == 0,
                  16'($urandom | $urandom),
                  16'($urandom | $urandom),
                  16'($urandom & $urandom),
                  16'($urandom & $urandom & $urandom & $urandom),
                  16'($urandom & $urandom & $urandom));
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
